i2c_slave: RTL and testbench

I2C target (slave) that answers the team's `i2c_master` on the shared open-drain SCL/SDA bus. It oversamples SCL and SDA on the system clock, detects START/STOP, matches a 7-bit address, ACKs, and delivers written bytes to the fabric. For reads it fetches bytes from the fabric and shifts them out. It is the counterpart block for master/slave loopback benches.

---
 rtl/i2c_pkg.sv | 25 ++
 rtl/i2c_line_sync.sv | 71 +++++++
 rtl/i2c_slave.sv | 178 +++++++++++++++++
 tb/tb_i2c_slave.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target.
package i2c_pkg;

    localparam int   I2C_ADDR_W = 7;
    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        WAIT_STOP
    } i2c_slave_state_t;

    // General call (address 0) is never answered.
    function automatic logic addr_match(input logic [I2C_ADDR_W-1:0] addr,
                                        input logic [I2C_ADDR_W-1:0] own);
        return (addr == own) && (addr != '0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line front end: 2-flop synchronizer, optional glitch filter
// (I2C_SLAVE_GLITCH_FILTER_EN) and registered rise/fall detection.
// level/rise/fall are mutually aligned: an event and its new level appear together.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic level_nxt;

    // Two-flop synchronizer; resets to the idle (pulled-up) bus level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: resetting to 1 (idle bus) avoids a false START/STOP right after reset.
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            // NOTE: non-blocking so sync_1/sync_2 form a real two-stage chain.
            sync_1 <= line_in;
            sync_2 <= sync_1;
        end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic hist_1;
    logic hist_2;

    // Keep the last two synchronized samples for the majority-free 3-sample filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_1 <= 1'b1;
            hist_2 <= 1'b1;
        end else begin
            hist_1 <= sync_2;
            hist_2 <= hist_1;
        end
    end

    // Output follows the line only after three consecutive equal samples.
    always_comb begin
        level_nxt = level;
        if ((sync_2 == hist_1) && (hist_1 == hist_2))
            level_nxt = sync_2;
    end
`else
    // Unfiltered: the level follows the synchronizer directly.
    always_comb begin
        level_nxt = sync_2;
    end
`endif

    // Register the level and its edges in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            level <= level_nxt;
            rise  <= level_nxt & ~level;
            fall  <= ~level_nxt & level;
        end
    end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: START/STOP detection, 7-bit address match, write delivery and
// read fetch. Define I2C_SLAVE_GLITCH_FILTER_EN to add the 3-sample line filter.
module i2c_slave import i2c_pkg::*; #(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h55
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl,
    inout  wire        i2c_sda,
    input  logic [7:0] r_data,
    output logic       r_req,
    output logic [7:0] w_data,
    output logic       w_valid,
    output logic       rw,
    output logic       busy
);

    logic scl_lv, scl_rise, scl_fall;
    logic sda_lv, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    i2c_slave_state_t state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic       drive_low, drive_low_nxt;
    logic       ack_seen, ack_seen_nxt;
    logic       rw_nxt, busy_nxt, w_valid_nxt, r_req_nxt;
    logic [7:0] w_data_nxt;
    logic [7:0] byte_in;

    i2c_line_sync u_scl_sync (
        .clk(clk), .reset(reset), .line_in(i2c_scl),
        .level(scl_lv), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_sync u_sda_sync (
        .clk(clk), .reset(reset), .line_in(i2c_sda),
        .level(sda_lv), .rise(sda_rise), .fall(sda_fall)
    );

    assign start_cond = sda_fall & scl_lv;
    assign stop_cond  = sda_rise & scl_lv;
    assign byte_in    = {shreg, sda_lv};
    assign i2c_sda    = drive_low ? 1'b0 : 1'bz;

    // State and datapath registers; reset releases SDA asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            drive_low <= 1'b0;
            ack_seen  <= 1'b0;
            rw        <= 1'b0;
            busy      <= 1'b0;
            w_data    <= 8'd0;
            w_valid   <= 1'b0;
            r_req     <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            drive_low <= drive_low_nxt;
            ack_seen  <= ack_seen_nxt;
            rw        <= rw_nxt;
            busy      <= busy_nxt;
            w_data    <= w_data_nxt;
            w_valid   <= w_valid_nxt;
            r_req     <= r_req_nxt;
        end
    end

    // Next-state logic; bus conditions override any bit activity.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        drive_low_nxt = drive_low;
        ack_seen_nxt  = ack_seen;
        rw_nxt        = rw;
        busy_nxt      = busy;
        w_data_nxt    = w_data;
        w_valid_nxt   = 1'b0;
        r_req_nxt     = 1'b0;

        if (start_cond) begin
            state_nxt     = ADDR;
            bit_cnt_nxt   = 3'd0;
            drive_low_nxt = 1'b0;
            busy_nxt      = 1'b0;
            ack_seen_nxt  = 1'b0;
        end else if (stop_cond) begin
            state_nxt     = IDLE;
            bit_cnt_nxt   = 3'd0;
            drive_low_nxt = 1'b0;
            busy_nxt      = 1'b0;
            ack_seen_nxt  = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (addr_match(byte_in[7:1], SLAVE_ADDR)) begin
                                rw_nxt    = byte_in[0];
                                busy_nxt  = 1'b1;
                                state_nxt = ADDR_ACK;
                            end else begin
                                state_nxt = WAIT_STOP;
                            end
                        end
                    end
                end
                // First fall starts the ACK, second fall ends it.
                ADDR_ACK, WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!drive_low) begin
                            drive_low_nxt = 1'b1;
                        end else if (state == WRITE_ACK || !rw) begin
                            drive_low_nxt = 1'b0;
                            state_nxt     = WRITE;
                        end else begin
                            r_req_nxt     = 1'b1;
                            shreg_nxt     = r_data[6:0];
                            drive_low_nxt = ~r_data[7];
                            bit_cnt_nxt   = 3'd0;
                            state_nxt     = READ;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shreg_nxt   = byte_in[6:0];
                        bit_cnt_nxt = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            w_data_nxt  = byte_in;
                            w_valid_nxt = 1'b1;
                            state_nxt   = WRITE_ACK;
                        end
                    end
                end
                // bit_cnt counts bits already placed on the bus; MSB went out on load.
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            drive_low_nxt = 1'b0;
                            bit_cnt_nxt   = 3'd0;
                            ack_seen_nxt  = 1'b0;
                            state_nxt     = READ_ACK;
                        end else begin
                            drive_low_nxt = ~shreg[6];
                            shreg_nxt     = {shreg[5:0], 1'b0};
                            bit_cnt_nxt   = bit_cnt + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise) begin
                        if (sda_lv == I2C_ACK) ack_seen_nxt = 1'b1;
                        else                   state_nxt    = WAIT_STOP;
                    end else if (scl_fall && ack_seen) begin
                        r_req_nxt     = 1'b1;
                        shreg_nxt     = r_data[6:0];
                        drive_low_nxt = ~r_data[7];
                        bit_cnt_nxt   = 3'd0;
                        ack_seen_nxt  = 1'b0;
                        state_nxt     = READ;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-level master tasks, a transaction-level
// model of expected ACKs, read bytes, pulse counts and busy/rw/w_data.
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int         Q   = 5;      // clk cycles per quarter SCL period
    localparam logic [6:0] OWN = 7'h55;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;                   // master side: 1 = release
    wire        sda_bus;
    logic [7:0] r_data;
    wire        r_req, w_valid, rw, busy;
    wire  [7:0] w_data;

    assign sda_bus = sda_m ? 1'bz : 1'b0;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(OWN)) dut (
        .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda_bus),
        .r_data(r_data), .r_req(r_req), .w_data(w_data),
        .w_valid(w_valid), .rw(rw), .busy(busy)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    logic       exp_busy = 1'b0;
    logic       exp_rw   = 1'b0;
    logic [7:0] exp_w_data = 8'd0;
    logic [7:0] exp_wq[$];
    int         exp_wv = 0, exp_rr = 0;
    int         wv_cnt = 0, rr_cnt = 0;
    logic       chk_en = 1'b0;
    logic [7:0] rd_bytes [256];
    logic [7:0] rd_ptr = 8'd0;
    logic       adv = 1'b0;
    logic [7:0] tx [4];

    assign r_data = rd_bytes[rd_ptr];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: pulses every cycle, levels during stable SCL-low windows.
    always @(negedge clk) begin
        adv <= r_req;
        if (adv) rd_ptr <= rd_ptr + 8'd1;
        if (r_req) rr_cnt <= rr_cnt + 1;
        if (w_valid) begin
            wv_cnt <= wv_cnt + 1;
            if (exp_wq.size() == 0) check("w_valid_unexpected", 32'd1, 32'd0);
            else                    check("w_valid_data", w_data, exp_wq.pop_front());
        end
        if (chk_en && !reset) begin
            check("busy", busy, exp_busy);
            check("rw", rw, exp_rw);
            check("w_data", w_data, exp_w_data);
        end
    end

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    // One SCL period: drive b, return the bus value sampled mid-high.
    task automatic bit_io(input logic b, output logic got);
        wait_q(1); sda_m = b; chk_en = 1'b1;
        wait_q(1); chk_en = 1'b0; scl = 1'b1;
        wait_q(1); got = sda_bus;
        wait_q(1); scl = 1'b0;
    endtask

    task automatic send8(input logic [7:0] b);
        logic g;
        for (int i = 7; i >= 0; i--) bit_io(b[i], g);
    endtask

    task automatic recv8(output logic [7:0] v);
        logic g;
        v = 8'd0;
        for (int i = 0; i < 8; i++) begin
            bit_io(1'b1, g);
            v = {v[6:0], g};
        end
    endtask

    task automatic do_start;
        if (scl) begin
            wait_q(1);
        end else begin
            wait_q(1); sda_m = 1'b1;
            wait_q(1); scl = 1'b1;
            wait_q(1);
        end
        sda_m = 1'b0;
        wait_q(2); scl = 1'b0;
        exp_busy = 1'b0;
    endtask

    task automatic do_stop;
        wait_q(1); sda_m = 1'b0;
        wait_q(1); scl = 1'b1;
        wait_q(1); sda_m = 1'b1;
        wait_q(2);
        exp_busy = 1'b0;
    endtask

    // Full transfer described at transaction level; data bytes come from tx[].
    task automatic xfer(input logic [6:0] a, input logic rd, input int n, input bit end_stop);
        logic       ack;
        logic [7:0] v;
        bit         match;
        match = (a == OWN) && (a != 7'd0);
        if (rd) for (int i = 0; i < n; i++) rd_bytes[rd_ptr + 8'(i)] = tx[i];
        do_start;
        send8({a, rd});
        if (match) begin
            exp_busy = 1'b1;
            exp_rw   = rd;
        end
        bit_io(1'b1, ack);
        check("addr_ack", ack, match ? I2C_ACK : I2C_NACK);
        if (match && !rd) begin
            for (int i = 0; i < n; i++) begin
                exp_wq.push_back(tx[i]);
                send8(tx[i]);
                exp_w_data = tx[i];
                exp_wv++;
                bit_io(1'b1, ack);
                check("data_ack", ack, I2C_ACK);
            end
        end else if (match) begin
            for (int i = 0; i < n; i++) begin
                exp_rr++;
                recv8(v);
                check("rd_byte", v, tx[i]);
                bit_io((i == n - 1) ? I2C_NACK : I2C_ACK, ack);
            end
        end
        if (end_stop) do_stop;
        check("w_valid_count", wv_cnt, exp_wv);
        check("r_req_count", rr_cnt, exp_rr);
    endtask

    initial begin
        logic       ack, g;
        logic [6:0] a;
        for (int i = 0; i < 256; i++) rd_bytes[i] = 8'd0;
        reset = 1'b1; scl = 1'b1; sda_m = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sda", sda_bus, 1'b1);
        check("rst_w_data", w_data, 8'h00);
        check("rst_w_valid", w_valid, 1'b0);
        check("rst_r_req", r_req, 1'b0);
        check("rst_rw", rw, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;
        wait_q(2);

        // Write 0x55/W, 0xAA
        tx[0] = 8'hAA;
        xfer(OWN, 1'b0, 1, 1'b1);
        wait_q(1);
        check("wr_w_data", w_data, 8'hAA);
        check("wr_one_pulse", wv_cnt, 1);
        check("wr_busy_after_stop", busy, 1'b0);

        // Foreign address: NACK, nothing happens
        tx[0] = 8'h12;
        xfer(7'h2A, 1'b0, 1, 1'b1);
        check("nack_no_pulse", wv_cnt, 1);
        check("nack_busy", busy, 1'b0);

        // Read 0xC3, master NACKs
        tx[0] = 8'hC3;
        xfer(OWN, 1'b1, 1, 1'b1);
        check("rd1_r_req", rr_cnt, 1);

        // Read 0x5A, 0x01 with ACK then NACK
        tx[0] = 8'h5A; tx[1] = 8'h01;
        xfer(OWN, 1'b1, 2, 1'b1);
        check("rd2_r_req", rr_cnt, 3);

        // Partial write then repeated START into a read
        do_start;
        send8({OWN, 1'b0});
        exp_busy = 1'b1; exp_rw = 1'b0;
        bit_io(1'b1, ack);
        check("rs_addr_ack", ack, I2C_ACK);
        for (int i = 0; i < 3; i++) bit_io(1'($urandom_range(0, 1)), g);
        tx[0] = 8'h96;
        xfer(OWN, 1'b1, 1, 1'b1);
        check("rs_no_w_valid", wv_cnt, 1);
        check("rs_rw", rw, 1'b1);

        // Reset while the target drives a 0 during READ
        rd_bytes[rd_ptr] = 8'h3C;
        do_start;
        send8({OWN, 1'b1});
        exp_busy = 1'b1; exp_rw = 1'b1;
        bit_io(1'b1, ack);
        check("rst_rd_addr_ack", ack, I2C_ACK);
        exp_rr++;
        wait_q(2);
        check("rst_rd_driving", sda_bus, 1'b0);
        #2 reset = 1'b1;
        #1 check("rst_async_release", sda_bus, 1'b1);
        @(negedge clk);
        check("rst2_busy", busy, 1'b0);
        check("rst2_rw", rw, 1'b0);
        check("rst2_w_data", w_data, 8'h00);
        check("rst2_r_req", r_req, 1'b0);
        exp_busy = 1'b0; exp_rw = 1'b0; exp_w_data = 8'h00;
        exp_wq.delete();
        scl = 1'b1; sda_m = 1'b1;
        wait_q(1);
        reset = 1'b0;
        wait_q(2);
        tx[0] = 8'h5C;
        xfer(OWN, 1'b0, 1, 1'b1);
        check("post_rst_w_data", w_data, 8'h5C);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : OWN;
            for (int i = 0; i < 4; i++) tx[i] = 8'($urandom_range(0, 255));
            xfer(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                 (t == 23) || ($urandom_range(0, 2) != 0));
        end
        wait_q(2);
        check("final_busy", busy, 1'b0);
        check("final_sda", sda_bus, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
